// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_pkg: instruction codes, FSM states and default widths for the serial   |
// | bus. MASTER_PARITY_EN adds one even-parity bit after each data word.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bus_pkg;

   localparam int DEF_ADDR_WIDTH  = 12;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_SLAVE_LEN   = 2;
   localparam int DEF_ACK_TIMEOUT = 255;

   localparam logic [1:0] INSTR_IDLE  = 2'b00;
   localparam logic [1:0] INSTR_READ  = 2'b01;
   localparam logic [1:0] INSTR_WRITE = 2'b10;

`ifdef MASTER_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      ADDR     = 3'd2,
      WAIT_ACK = 3'd3,
      WDATA    = 3'd4,
      RDATA    = 3'd5,
      DONE     = 3'd6
   } state_e;

   function automatic logic is_xfer(input logic [1:0] instr);
      return (instr == INSTR_READ) || (instr == INSTR_WRITE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/master_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | master_port_if: shared serial bus signals between master, slave, arbiter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface master_port_if;
   logic bus_req;
   logic bus_grant;
   logic m_valid;
   logic m_mode;
   logic m_dout;
   logic slave_ready;
   logic m_din;
   logic m_rd_valid;

   modport master (
      output bus_req, m_valid, m_mode, m_dout,
      input  bus_grant, slave_ready, m_din, m_rd_valid
   );

   modport slave (
      input  bus_req, m_valid, m_mode, m_dout,
      output bus_grant, slave_ready, m_din, m_rd_valid
   );
endinterface
`default_nettype wire

// File: rtl/bus_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_shift_reg: loadable LSB-first shifter, serial out and serial in, with a |
// | per-load bit length and a last-bit flag. Revision: 1.0                     |
// +----------------------------------------------------------------------------+
module bus_shift_reg #(
   parameter  int WIDTH  = 14,
   parameter  int WORD_W = 8,
   localparam int LEN_W  = $clog2(WIDTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [LEN_W-1:0]  load_len,
   input  logic              shift,
   input  logic              shift_in,
   output logic              serial_out,
   output logic              last_bit,
   output logic [WORD_W-1:0] word_next
);

   logic [WIDTH-1:0] q_q, q_d, shifted;
   logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
   logic [LEN_W-1:0] ins_pos;

   // Serial-in bits enter at the top of the active length so that after
   // len shifts the first bit received sits at bit 0.
   always_comb begin
      ins_pos = len_q - LEN_W'(1);
      shifted = q_q >> 1;
      if (shift_in) begin
         shifted = shifted | (WIDTH'(1) << ins_pos);
      end
      q_d   = q_q;
      cnt_d = cnt_q;
      len_d = len_q;
      if (load) begin
         q_d   = load_val;
         cnt_d = '0;
         len_d = load_len;
      end else if (shift) begin
         q_d   = shifted;
         cnt_d = cnt_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q   <= '0;
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   assign serial_out = q_q[0];
   assign last_bit   = (cnt_q == ins_pos);
   assign word_next  = shifted[WORD_W-1:0];

endmodule
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | master_port: arbitrates for the serial bus and runs one read or write per  |
// | request. MASTER_PARITY_EN appends/checks an even-parity bit. Revision: 1.0 |
// +----------------------------------------------------------------------------+
module master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int SLAVE_LEN   = DEF_SLAVE_LEN,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            instruction,
   input  logic [SLAVE_LEN-1:0]  slave_select,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  tx_done,
   output logic                  ack_fail,
   master_port_if.master         bus
);

   localparam int ADDR_BITS = SLAVE_LEN + ADDR_WIDTH;
   localparam int SER_W     = DATA_WIDTH + PAR_BITS;
   localparam int SH_W      = (ADDR_BITS > SER_W) ? ADDR_BITS : SER_W;
   localparam int LEN_W     = $clog2(SH_W + 1);
   localparam int CNT_W     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_e                state_q, state_d;
   logic                  armed_q, armed_d;
   logic                  mode_q, mode_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]      ack_cnt_q, ack_cnt_d;
   logic                  ack_fail_q, ack_fail_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   logic              sh_load, sh_shift, sh_shift_in, sh_serial, sh_last;
   logic [SH_W-1:0]   sh_load_val;
   logic [LEN_W-1:0]  sh_load_len;
   logic [SER_W-1:0]  sh_word;
   logic [SER_W-1:0]  wdata_word;
   logic              rd_ok;
   logic              bus_req_w, m_valid_w;

`ifdef MASTER_PARITY_EN
   assign wdata_word = {^wdata_q, wdata_q};
   assign rd_ok      = ~(^sh_word);
`else
   assign wdata_word = wdata_q;
   assign rd_ok      = 1'b1;
`endif

   bus_shift_reg #(
      .WIDTH  (SH_W),
      .WORD_W (SER_W)
   ) u_shift (
      .clk        (clk),
      .reset      (reset),
      .load       (sh_load),
      .load_val   (sh_load_val),
      .load_len   (sh_load_len),
      .shift      (sh_shift),
      .shift_in   (sh_shift_in),
      .serial_out (sh_serial),
      .last_bit   (sh_last),
      .word_next  (sh_word)
   );

   assign sh_shift_in = (state_q == RDATA) & bus.m_din;

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      mode_d      = mode_q;
      wdata_d     = wdata_q;
      ack_cnt_d   = ack_cnt_q;
      ack_fail_d  = ack_fail_q;
      data_out_d  = data_out_q;
      sh_load     = 1'b0;
      sh_load_val = '0;
      sh_load_len = '0;
      sh_shift    = 1'b0;
      case (state_q)
         IDLE: begin
            if (instruction == INSTR_IDLE) begin
               armed_d = 1'b1;
            end else if (armed_q && is_xfer(instruction)) begin
               mode_d                       = (instruction == INSTR_WRITE);
               wdata_d                      = data_in;
               ack_fail_d                   = 1'b0;
               sh_load                      = 1'b1;
               sh_load_val[ADDR_BITS-1:0]   = {address, slave_select};
               sh_load_len                  = LEN_W'(ADDR_BITS);
               state_d                      = REQ;
            end
         end
         REQ: begin
            if (bus.bus_grant) state_d = ADDR;
         end
         ADDR: begin
            if (!bus.bus_grant) begin
               state_d    = DONE;
               ack_fail_d = 1'b1;
            end else begin
               sh_shift  = 1'b1;
               ack_cnt_d = '0;
               if (sh_last) state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!bus.bus_grant) begin
               state_d    = DONE;
               ack_fail_d = 1'b1;
            end else if (bus.slave_ready) begin
               sh_load                  = 1'b1;
               sh_load_val[SER_W-1:0]   = mode_q ? wdata_word : '0;
               sh_load_len              = LEN_W'(SER_W);
               ack_cnt_d                = '0;
               state_d                  = mode_q ? WDATA : RDATA;
            end else if (ack_cnt_q == ACK_LAST) begin
               state_d    = DONE;
               ack_fail_d = 1'b1;
            end else begin
               ack_cnt_d = ack_cnt_q + CNT_W'(1);
            end
         end
         WDATA: begin
            if (!bus.bus_grant) begin
               state_d    = DONE;
               ack_fail_d = 1'b1;
            end else begin
               sh_shift = 1'b1;
               if (sh_last) state_d = DONE;
            end
         end
         RDATA: begin
            if (!bus.bus_grant) begin
               state_d    = DONE;
               ack_fail_d = 1'b1;
            end else if (bus.m_rd_valid) begin
               sh_shift  = 1'b1;
               ack_cnt_d = '0;
               if (sh_last) begin
                  state_d = DONE;
                  if (rd_ok) data_out_d = sh_word[DATA_WIDTH-1:0];
                  else       ack_fail_d = 1'b1;
               end
            end else if (ack_cnt_q == ACK_LAST) begin
               state_d    = DONE;
               ack_fail_d = 1'b1;
            end else begin
               ack_cnt_d = ack_cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // Disarm so a request still held after tx_done is not re-issued.
            armed_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         armed_q    <= 1'b1;
         mode_q     <= 1'b0;
         wdata_q    <= '0;
         ack_cnt_q  <= '0;
         ack_fail_q <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         mode_q     <= mode_d;
         wdata_q    <= wdata_d;
         ack_cnt_q  <= ack_cnt_d;
         ack_fail_q <= ack_fail_d;
         data_out_q <= data_out_d;
      end
   end

   assign bus_req_w = (state_q == REQ) || (state_q == ADDR) || (state_q == WAIT_ACK) ||
                      (state_q == WDATA) || (state_q == RDATA);
   assign m_valid_w = ((state_q == ADDR) || (state_q == WDATA)) && bus.bus_grant;

   assign bus.bus_req = bus_req_w;
   assign bus.m_valid = m_valid_w;
   assign bus.m_mode  = bus_req_w & mode_q;
   assign bus.m_dout  = m_valid_w & sh_serial;

   assign data_out = data_out_q;
   assign ack_fail = ack_fail_q;
   assign tx_done  = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_master_port: directed bench for master_port with a cycle-scheduled      |
// | slave/arbiter model. Revision: 1.0                                         |
// +----------------------------------------------------------------------------+
module tb_master_port;
   import bus_pkg::*;

   localparam int PB = PAR_BITS;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] instruction;
   logic [1:0] slave_select;
   logic [11:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       tx_done;
   logic       ack_fail;

   master_port_if bus();

   master_port #(
      .ADDR_WIDTH  (12),
      .DATA_WIDTH  (8),
      .SLAVE_LEN   (2),
      .ACK_TIMEOUT (255)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .instruction  (instruction),
      .slave_select (slave_select),
      .address      (address),
      .data_in      (data_in),
      .data_out     (data_out),
      .tx_done      (tx_done),
      .ack_fail     (ack_fail),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int          done_c, nb;
   logic [31:0] bits;
   logic        mode_bad, any_done, valid_drop;
   logic [13:0] rst_next;
   logic        bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [13:0] outs();
      return {data_out, tx_done, ack_fail, bus.bus_req, bus.m_valid, bus.m_mode, bus.m_dout};
   endfunction

   // Cycle c=1 is the cycle after the latch edge. The slave raises slave_ready
   // in cycle ready_c and then serves read bits with a 2-cycle gap after bit 2.
   task automatic xfer(input logic [1:0] instr, input logic [1:0] ss, input logic [11:0] addr,
                       input logic [7:0] din, input int ready_c, input int drop_c,
                       input int rst_c, input logic [8:0] rd_word, input bit hold,
                       input int max_c);
      logic exp_mode;
      int   s, idx;
      exp_mode = (instr == INSTR_WRITE);
      done_c = 0; nb = 0; bits = '0; mode_bad = 0; any_done = 0; valid_drop = 1'bx;
      rst_next = 'x;
      instruction = INSTR_IDLE;
      tick();
      tick();
      instruction  = instr;
      slave_select = ss;
      address      = addr;
      data_in      = din;
      tick();
      for (int c = 1; c <= max_c; c++) begin
         if (!hold) instruction = INSTR_IDLE;
         slave_select = '0;
         address      = '0;
         data_in      = '0;
         bus.slave_ready = (c == ready_c);
         if (c == drop_c) bus.bus_grant = 1'b0;
         if (c == rst_c)  reset = 1'b0;
         bus.m_rd_valid = 1'b0;
         bus.m_din      = 1'b0;
         s = c - ready_c - 1;
         if (instr == INSTR_READ && ready_c > 0 && s >= 0 && s != 3 && s != 4) begin
            idx = (s < 3) ? s : s - 2;
            if (idx < 8 + PB) begin
               bus.m_rd_valid = 1'b1;
               bus.m_din      = rd_word[idx];
            end
         end
         #1;
         if (bus.m_valid && nb < 32) begin
            bits[nb] = bus.m_dout;
            nb++;
         end
         if (c == drop_c) valid_drop = bus.m_valid;
         if (rst_c > 0 && c == rst_c + 1) rst_next = outs();
         if (bus.bus_req && bus.m_mode !== exp_mode) mode_bad = 1'b1;
         if (tx_done) begin
            any_done = 1'b1;
            if (done_c == 0) done_c = c;
            if (rst_c == 0) break;
         end
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; instruction = INSTR_IDLE; slave_select = '0; address = '0; data_in = '0;
      bus.bus_grant = 1'b0; bus.slave_ready = 1'b0; bus.m_din = 1'b0; bus.m_rd_valid = 1'b0;
      tick();
      tick();
      check("reset_outputs", 32'(outs()), 32'h0);
      reset = 1'b1;

      instruction = 2'b11;
      bad = 1'b0;
      repeat (4) begin
         tick();
         if (bus.bus_req) bad = 1'b1;
      end
      check("reserved_no_req", 32'(bad), 32'h0);

      // Write 3C to 0A5 on slave 1, slave_ready in 3rd wait cycle
      bus.bus_grant = 1'b1;
      xfer(INSTR_WRITE, 2'b01, 12'h0A5, 8'h3C, 18, 0, 0, 9'h000, 1'b0, 60);
      check("wr_done_cycle", done_c, 27 + PB);
      check("wr_nbits", nb, 22 + PB);
      check("wr_bits", bits, {10'b0, 8'h3C, 12'h0A5, 2'b01});
      check("wr_ack_fail", 32'(ack_fail), 32'h0);
      check("wr_mode", 32'(mode_bad), 32'h0);
      check("wr_req_in_done", 32'(bus.bus_req), 32'h0);
      tick();
      check("wr_done_pulse", 32'(tx_done), 32'h0);

      // Read 96 from 100 on slave 2 with a gap in m_rd_valid
      xfer(INSTR_READ, 2'b10, 12'h100, 8'h00, 18, 0, 0, {1'b0, 8'h96}, 1'b0, 60);
      check("rd_done_cycle", done_c, 29 + PB);
      check("rd_data_out", 32'(data_out), 32'h96);
      check("rd_ack_fail", 32'(ack_fail), 32'h0);
      check("rd_mode", 32'(mode_bad), 32'h0);
      check("rd_addr_bits", bits, {18'b0, 12'h100, 2'b10});
      tick();

      // Slave never acknowledges
      xfer(INSTR_READ, 2'b00, 12'h3FF, 8'h00, 0, 0, 0, 9'h000, 1'b0, 400);
      check("to_done_cycle", done_c, 271);
      check("to_ack_fail", 32'(ack_fail), 32'h1);
      check("to_data_out", 32'(data_out), 32'h96);
      tick();
      check("to_req_after", 32'({bus.bus_req, tx_done}), 32'h0);

`ifdef MASTER_PARITY_EN
      xfer(INSTR_WRITE, 2'b00, 12'h000, 8'h07, 18, 0, 0, 9'h000, 1'b0, 60);
      check("par_wr_bit", 32'(bits[22]), 32'h1);
      tick();
      xfer(INSTR_READ, 2'b00, 12'h001, 8'h00, 18, 0, 0, {1'b1, 8'h55}, 1'b0, 60);
      check("par_rd_fail", 32'(ack_fail), 32'h1);
      check("par_rd_held", 32'(data_out), 32'h96);
      tick();
`endif

      // Grant lost during the 5th address bit, request held afterwards
      xfer(INSTR_WRITE, 2'b11, 12'h123, 8'hAA, 18, 6, 0, 9'h000, 1'b1, 60);
      check("gl_valid_at_drop", 32'(valid_drop), 32'h0);
      check("gl_done_cycle", done_c, 7);
      check("gl_ack_fail", 32'(ack_fail), 32'h1);
      check("gl_bits", bits, 32'hF);
      check("gl_data_out", 32'(data_out), 32'h96);
      bad = 1'b0;
      repeat (3) begin
         tick();
         if (bus.bus_req) bad = 1'b1;
      end
      check("gl_no_reissue", 32'(bad), 32'h0);
      instruction = INSTR_IDLE;
      tick();
      instruction = INSTR_WRITE;
      tick();
      check("gl_rearm_req", 32'(bus.bus_req), 32'h1);
      reset = 1'b0;
      tick();
      check("rst_from_req", 32'(outs()), 32'h0);
      reset = 1'b1;
      bus.bus_grant = 1'b1;

      // Reset asserted in the middle of WDATA
      xfer(INSTR_WRITE, 2'b01, 12'h0A5, 8'h3C, 18, 0, 21, 9'h000, 1'b0, 40);
      check("rst_next_outputs", 32'(rst_next), 32'h0);
      check("rst_no_done", 32'(any_done), 32'h0);
      check("rst_held_outputs", 32'(outs()), 32'h0);
      reset = 1'b1;
      tick();
      check("rst_release_idle", 32'({tx_done, bus.bus_req, ack_fail}), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
